// File: rtl/env_pkg.sv
// env_pkg -- shared constants for the 3x3 grid-world environment.
//
// Holds the action encoding, the grid width, the default reward values,
// the trap state/reward constants (used only when ENV_TRAP_EN is defined)
// and a saturating accumulator helper for the 12-bit episode return.
package env_pkg;

    // Action encoding as presented on the action port.
    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    // Grid geometry: states are numbered 1..GRID_W*GRID_W, row-major.
    localparam int GRID_W     = 3;
    localparam int GRID_CELLS = GRID_W * GRID_W;

    // Default rewards (signed 8-bit).
    localparam logic signed [7:0] R_STEP_DEF = -8'sd1;
    localparam logic signed [7:0] R_WALL_DEF = -8'sd2;
    localparam logic signed [7:0] R_GOAL_DEF = 8'sd10;

    // Trap cell, terminal only when ENV_TRAP_EN is defined.
    localparam logic [3:0]        TRAP_ST = 4'd5;
    localparam logic signed [7:0] R_TRAP  = -8'sd10;

    // Episode return limits (signed 12-bit).
    localparam logic signed [11:0] RET_MAX = 12'sd2047;
    localparam logic signed [11:0] RET_MIN = -12'sd2048;

    // Add a reward to the return, clamping at the 12-bit signed limits.
    // Overflow is detected from the two top bits of a 13-bit sum.
    function automatic logic signed [11:0] sat_add(
        input logic signed [11:0] acc,
        input logic signed [7:0]  r
    );
        logic signed [12:0] sum;
        sum = {acc[11], acc} + {{5{r[7]}}, r};
        if (sum[12] != sum[11]) begin
            sat_add = sum[12] ? RET_MIN : RET_MAX;
        end else begin
            sat_add = sum[11:0];
        end
    endfunction

endpackage

// File: rtl/env_move.sv
// env_move -- combinational grid transition for the 3x3 grid world.
//
// Ports:
//   st     in  [3:0] current state, 1..9 row-major
//   action in  [1:0] 0=up 1=right 2=down 3=left
//   nxt    out [3:0] resulting state (equals st when the move hits a wall)
//   wall   out       high when the move would leave the grid
module env_move
    import env_pkg::*;
(
    input  logic [3:0] st,
    input  logic [1:0] action,
    output logic [3:0] nxt,
    output logic       wall
);

    localparam logic [3:0] W      = 4'(GRID_W);
    localparam logic [3:0] W2     = 4'(2 * GRID_W);
    localparam logic [3:0] CELLS  = 4'(GRID_CELLS);
    localparam logic [1:0] EDGE   = 2'(GRID_W - 1);

    logic [3:0] idx;
    logic [1:0] row;
    logic [1:0] col;
    logic       in_range;

    always_comb begin
        idx      = st - 4'd1;
        in_range = (st >= 4'd1) && (st <= CELLS);

        // Row/column split without a divider: three rows only.
        if (idx < W) begin
            row = 2'd0;
            col = idx[1:0];
        end else if (idx < W2) begin
            row = 2'd1;
            col = 2'(idx - W);
        end else begin
            row = 2'd2;
            col = 2'(idx - W2);
        end

        nxt  = st;
        wall = 1'b0;
        case (action_e'(action))
            ACT_UP: begin
                if (row == 2'd0) wall = 1'b1;
                else             nxt  = st - W;
            end
            ACT_RIGHT: begin
                if (col == EDGE) wall = 1'b1;
                else             nxt  = st + 4'd1;
            end
            ACT_DOWN: begin
                if (row == EDGE) wall = 1'b1;
                else             nxt  = st + W;
            end
            default: begin
                if (col == 2'd0) wall = 1'b1;
                else             nxt  = st - 4'd1;
            end
        endcase

        // A corrupted state never propagates: treat it as a wall bump.
        if (!in_range) begin
            nxt  = st;
            wall = 1'b1;
        end
    end

endmodule

// File: rtl/grid_env.sv
// grid_env -- 3x3 grid-world environment driven by a phase controller.
//
// On controller==ACT_PHASE the next state, reward and done flag are
// sampled from the current state and action, and the reward is added
// (saturating) to the episode return. On controller==COMMIT_PHASE the
// state advances, or restarts at START_ST when the episode is done or
// the step count has reached 15. Other controller values hold everything.
//
// Optional feature: define ENV_TRAP_EN to make state 5 a terminal trap
// cell (reward -10, done=1).
//
// Ports:
//   clk        in        clock, rising edge
//   rst        in        asynchronous active-low reset
//   controller in  [3:0] phase 1..9, 0 = idle
//   step       in  [3:0] step-in-episode count
//   action     in  [1:0] 0=up 1=right 2=down 3=left
//   st         out [3:0] current state
//   st1        out [3:0] next state
//   reward     out [7:0] signed reward of last sampled transition
//   done       out       st1 is terminal
//   ret        out [11:0] signed cumulative episode return
module grid_env
    import env_pkg::*;
#(
    parameter logic [3:0]        ACT_PHASE    = 4'd2,
    parameter logic [3:0]        COMMIT_PHASE = 4'd9,
    parameter logic [3:0]        START_ST     = 4'd1,
    parameter logic [3:0]        GOAL_ST      = 4'd9,
    parameter logic signed [7:0] R_STEP       = R_STEP_DEF,
    parameter logic signed [7:0] R_WALL       = R_WALL_DEF,
    parameter logic signed [7:0] R_GOAL       = R_GOAL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         controller,
    input  logic [3:0]         step,
    input  logic [1:0]         action,
    output logic [3:0]         st,
    output logic [3:0]         st1,
    output logic signed [7:0]  reward,
    output logic               done,
    output logic signed [11:0] ret
);

    logic [3:0]         st_reg;
    logic [3:0]         st1_reg;
    logic signed [7:0]  reward_reg;
    logic               done_reg;
    logic signed [11:0] ret_reg;

    logic [3:0]         move_nxt;
    logic               move_wall;
    logic signed [7:0]  reward_next;
    logic               done_next;
    logic               restart;

    env_move u_move (
        .st     (st_reg),
        .action (action),
        .nxt    (move_nxt),
        .wall   (move_wall)
    );

    // Reward and terminal flag of the move that would be sampled now.
    always_comb begin
        reward_next = R_STEP;
        done_next   = 1'b0;
        if (move_wall) begin
            reward_next = R_WALL;
        end else if (move_nxt == GOAL_ST) begin
            reward_next = R_GOAL;
            done_next   = 1'b1;
        end
`ifdef ENV_TRAP_EN
        else if (move_nxt == TRAP_ST) begin
            reward_next = R_TRAP;
            done_next   = 1'b1;
        end
`endif
    end

    // Goal on the last step and step-limit expiry share one restart.
    assign restart = done_reg || (step == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_reg     <= START_ST;
            st1_reg    <= START_ST;
            reward_reg <= '0;
            done_reg   <= 1'b0;
            ret_reg    <= '0;
        end else if (controller == ACT_PHASE) begin
            st1_reg    <= move_nxt;
            reward_reg <= reward_next;
            done_reg   <= done_next;
            ret_reg    <= sat_add(ret_reg, reward_next);
        end else if (controller == COMMIT_PHASE) begin
            if (restart) begin
                st_reg   <= START_ST;
                done_reg <= 1'b0;
                ret_reg  <= '0;
            end else begin
                // Without a sample this cycle, the held st1 is re-committed.
                st_reg <= st1_reg;
            end
        end
    end

    assign st     = st_reg;
    assign st1    = st1_reg;
    assign reward = reward_reg;
    assign done   = done_reg;
    assign ret    = ret_reg;

endmodule

// File: tb/tb_grid_env.sv
// tb_grid_env -- self-checking bench for grid_env.
// Directed scenarios plus randomized episodes against a row/column
// reference model of the grid world.
module tb_grid_env;

`ifdef ENV_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         controller;
    logic [3:0]         step;
    logic [1:0]         action;
    logic [3:0]         st;
    logic [3:0]         st1;
    logic signed [7:0]  reward;
    logic               done;
    logic signed [11:0] ret;

    int tests_run = 0;
    int failures  = 0;

    // Reference model state.
    int m_st, m_st1, m_reward, m_done, m_ret;

    always #5 clk = ~clk;

    grid_env dut (
        .clk        (clk),
        .rst        (rst),
        .controller (controller),
        .step       (step),
        .action     (action),
        .st         (st),
        .st1        (st1),
        .reward     (reward),
        .done       (done),
        .ret        (ret)
    );

    function automatic void model_reset();
        m_st = 1; m_st1 = 1; m_reward = 0; m_done = 0; m_ret = 0;
    endfunction

    // Sample: move on a (row, col) view of the grid.
    function automatic void model_act(input int a);
        int r, c, nr, nc, n;
        bit wall;
        r = (m_st - 1) / 3;
        c = (m_st - 1) % 3;
        nr = r; nc = c;
        case (a)
            0: nr = r - 1;
            1: nc = c + 1;
            2: nr = r + 1;
            default: nc = c - 1;
        endcase
        wall = (nr < 0) || (nr > 2) || (nc < 0) || (nc > 2);
        n = wall ? m_st : nr * 3 + nc + 1;
        m_st1 = n;
        m_done = 0;
        if (wall) m_reward = -2;
        else if (n == 9) begin m_reward = 10; m_done = 1; end
        else if (TRAP && n == 5) begin m_reward = -10; m_done = 1; end
        else m_reward = -1;
        m_ret = m_ret + m_reward;
        if (m_ret > 2047) m_ret = 2047;
        if (m_ret < -2048) m_ret = -2048;
    endfunction

    function automatic void model_commit(input int s);
        if (m_done != 0 || s == 15) begin
            m_st = 1; m_done = 0; m_ret = 0;
        end else begin
            m_st = m_st1;
        end
    endfunction

    // Walk the controller through phases from..to; skip_act replaces
    // the sampling phase with a repeated phase 1.
    task automatic drive_phases(input int from, input int to, input bit skip_act);
        for (int p = from; p <= to; p++) begin
            controller = (p == 2 && skip_act) ? 4'd1 : 4'(p);
            @(posedge clk);
            if (controller == 4'd2) model_act(int'(action));
            else if (controller == 4'd9) model_commit(int'(step));
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        controller = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL reset_st: got %0d expected 1", st); end
        tests_run++; if (st1 !== 4'd1) begin failures++; $display("FAIL reset_st1: got %0d expected 1", st1); end
        tests_run++; if (reward !== 8'sd0) begin failures++; $display("FAIL reset_reward: got %0d expected 0", reward); end
        tests_run++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        tests_run++; if (ret !== 12'sd0) begin failures++; $display("FAIL reset_ret: got %0d expected 0", ret); end
        $display("[TB] reset: st=%0d st1=%0d reward=%0d ret=%0d", st, st1, reward, ret);
    endtask

    task automatic test_wall();
        do_reset();
        action = 2'd0; step = 4'd0;
        drive_phases(1, 2, 1'b0);
        tests_run++; if (st1 !== 4'd1) begin failures++; $display("FAIL wall_st1: got %0d expected 1", st1); end
        tests_run++; if (reward !== -8'sd2) begin failures++; $display("FAIL wall_reward: got %0d expected -2", reward); end
        drive_phases(3, 9, 1'b0);
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL wall_st: got %0d expected 1", st); end
        $display("[TB] wall: st=%0d reward=%0d ret=%0d", st, reward, ret);
    endtask

    task automatic test_goal_path();
        int acts [4] = '{1, 1, 2, 2};
        int exp_st1 [4] = '{2, 3, 6, 9};
        int exp_ret [4] = '{-1, -2, -3, 7};
        do_reset();
        step = 4'd0;
        for (int i = 0; i < 4; i++) begin
            action = 2'(acts[i]);
            drive_phases(1, 2, 1'b0);
            tests_run++; if (int'(st1) !== exp_st1[i]) begin failures++; $display("FAIL goal_st1[%0d]: got %0d expected %0d", i, st1, exp_st1[i]); end
            tests_run++; if (int'(ret) !== exp_ret[i]) begin failures++; $display("FAIL goal_ret[%0d]: got %0d expected %0d", i, ret, exp_ret[i]); end
            if (i == 3) begin
                tests_run++; if (reward !== 8'sd10) begin failures++; $display("FAIL goal_reward: got %0d expected 10", reward); end
                tests_run++; if (done !== 1'b1) begin failures++; $display("FAIL goal_done: got %0b expected 1", done); end
            end
            drive_phases(3, 9, 1'b0);
            $display("[TB] goal step %0d: st=%0d st1=%0d ret=%0d", i, st, st1, ret);
        end
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL goal_restart_st: got %0d expected 1", st); end
        tests_run++; if (ret !== 12'sd0) begin failures++; $display("FAIL goal_restart_ret: got %0d expected 0", ret); end
        tests_run++; if (done !== 1'b0) begin failures++; $display("FAIL goal_restart_done: got %0b expected 0", done); end
    endtask

    task automatic test_step15();
        do_reset();
        action = 2'd2; step = 4'd0;
        drive_phases(1, 9, 1'b0);
        tests_run++; if (st !== 4'd4) begin failures++; $display("FAIL s15_setup_st: got %0d expected 4", st); end
        action = 2'd1; step = 4'd15;
        drive_phases(1, 2, 1'b0);
        tests_run++; if (st1 !== 4'd5) begin failures++; $display("FAIL s15_st1: got %0d expected 5", st1); end
        drive_phases(3, 9, 1'b0);
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL s15_restart_st: got %0d expected 1", st); end
        tests_run++; if (ret !== 12'sd0) begin failures++; $display("FAIL s15_restart_ret: got %0d expected 0", ret); end
        $display("[TB] step15: st=%0d st1=%0d ret=%0d", st, st1, ret);
    endtask

    task automatic test_goal_at_15();
        int acts [3] = '{1, 1, 2};
        do_reset();
        step = 4'd0;
        for (int i = 0; i < 3; i++) begin
            action = 2'(acts[i]);
            drive_phases(1, 9, 1'b0);
        end
        action = 2'd2; step = 4'd15;
        drive_phases(1, 2, 1'b0);
        tests_run++; if (ret !== 12'sd7) begin failures++; $display("FAIL g15_ret: got %0d expected 7", ret); end
        drive_phases(3, 9, 1'b0);
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL g15_st: got %0d expected 1", st); end
        step = 4'd0; action = 2'd1;
        drive_phases(1, 9, 1'b0);
        tests_run++; if (st !== 4'd2) begin failures++; $display("FAIL g15_after_st: got %0d expected 2", st); end
        $display("[TB] goal at step15: st=%0d ret=%0d", st, ret);
    endtask

    task automatic test_trap();
        do_reset();
        action = 2'd1; step = 4'd0;
        drive_phases(1, 9, 1'b0);
        action = 2'd2;
        drive_phases(1, 2, 1'b0);
        tests_run++; if (st1 !== 4'd5) begin failures++; $display("FAIL trap_st1: got %0d expected 5", st1); end
        tests_run++; if (reward !== (TRAP ? -8'sd10 : -8'sd1)) begin failures++; $display("FAIL trap_reward: got %0d expected %0d", reward, TRAP ? -10 : -1); end
        tests_run++; if (done !== TRAP) begin failures++; $display("FAIL trap_done: got %0b expected %0b", done, TRAP); end
        drive_phases(3, 9, 1'b0);
        tests_run++; if (st !== (TRAP ? 4'd1 : 4'd5)) begin failures++; $display("FAIL trap_commit_st: got %0d expected %0d", st, TRAP ? 1 : 5); end
        $display("[TB] trap: st=%0d reward=%0d", st, reward);
    endtask

    task automatic test_idle();
        logic [3:0] s0, s10;
        logic signed [7:0] r0;
        logic signed [11:0] t0;
        logic d0;
        do_reset();
        action = 2'd1; step = 4'd0;
        drive_phases(1, 2, 1'b0);
        s0 = st; s10 = st1; r0 = reward; t0 = ret; d0 = done;
        for (int i = 0; i < 8; i++) begin
            action = 2'($urandom_range(0, 3));
            step = 4'($urandom_range(0, 15));
            controller = (i < 4) ? 4'd0 : 4'($urandom_range(10, 15));
            @(posedge clk); #1;
        end
        tests_run++; if ({st, st1, reward, done, ret} !== {s0, s10, r0, d0, t0}) begin
            failures++; $display("FAIL idle_hold: got st=%0d st1=%0d ret=%0d expected st=%0d st1=%0d ret=%0d", st, st1, ret, s0, s10, t0);
        end
        tests_run++; if (st1 !== 4'd2) begin failures++; $display("FAIL idle_st1: got %0d expected 2", st1); end
        $display("[TB] idle: st=%0d st1=%0d ret=%0d", st, st1, ret);
        action = 2'd1; step = 4'd0;
        drive_phases(3, 9, 1'b0);
    endtask

    task automatic test_reset_midcycle();
        do_reset();
        action = 2'd2; step = 4'd0;
        drive_phases(1, 9, 1'b0);
        action = 2'd1;
        drive_phases(1, 5, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        tests_run++; if ({st, st1, reward, done, ret} !== {4'd1, 4'd1, 8'd0, 1'b0, 12'd0}) begin
            failures++; $display("FAIL midreset: got st=%0d st1=%0d reward=%0d done=%0b ret=%0d expected 1 1 0 0 0", st, st1, reward, done, ret);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        drive_phases(6, 9, 1'b0);
        tests_run++; if (st !== 4'd1) begin failures++; $display("FAIL midreset_resume: got %0d expected 1", st); end
        action = 2'd1;
        drive_phases(1, 9, 1'b0);
        tests_run++; if (st !== 4'd2) begin failures++; $display("FAIL midreset_next: got %0d expected 2", st); end
        $display("[TB] mid-cycle reset: st=%0d", st);
    endtask

    task automatic test_random();
        bit skip;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            action = 2'($urandom_range(0, 3));
            step = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            skip = ($urandom_range(0, 9) == 0);
            drive_phases(1, 2, skip);
            tests_run++; if (int'(st1) !== m_st1 || int'(reward) !== m_reward || int'(done) !== m_done || int'(ret) !== m_ret) begin
                failures++; $display("FAIL rand_act[%0d]: got st1=%0d reward=%0d done=%0b ret=%0d expected %0d %0d %0d %0d", i, st1, reward, done, ret, m_st1, m_reward, m_done, m_ret);
            end
            if ($urandom_range(0, 4) == 0) begin
                controller = 4'd0;
                @(posedge clk); #1;
            end
            drive_phases(3, 9, 1'b0);
            tests_run++; if (int'(st) !== m_st || int'(done) !== m_done || int'(ret) !== m_ret || st < 4'd1 || st > 4'd9) begin
                failures++; $display("FAIL rand_commit[%0d]: got st=%0d done=%0b ret=%0d expected %0d %0d %0d", i, st, done, ret, m_st, m_done, m_ret);
            end
            $display("[TB] rand %0d: act=%0d step=%0d skip=%0b st=%0d st1=%0d reward=%0d ret=%0d", i, action, step, skip, st, st1, reward, ret);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        action = 2'd0; step = 4'd0;
        for (int i = 0; i < 1030; i++) begin
            drive_phases(2, 2, 1'b0);
            drive_phases(9, 9, 1'b0);
            if (i == 1022) begin
                tests_run++; if (ret !== -12'sd2046) begin failures++; $display("FAIL sat_pre: got %0d expected -2046", ret); end
            end
        end
        tests_run++; if (ret !== -12'sd2048 || int'(ret) !== m_ret) begin failures++; $display("FAIL sat_min: got %0d expected -2048", ret); end
        $display("[TB] saturation: ret=%0d", ret);
    endtask

    initial begin
        rst = 1'b0;
        controller = 4'd0;
        step = 4'd0;
        action = 2'd0;
        model_reset();
        test_reset();
        test_wall();
        test_goal_path();
        test_step15();
        test_goal_at_15();
        test_trap();
        test_idle();
        test_reset_midcycle();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
